// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter: two source FIFOs drained round-robin into the register-bank write port.
// Define REGBANK_WB_FIXED_PRIO_EN to give the memory-load source fixed priority.
module regbank_wb_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_alu_valid,
  output logic                 o_alu_ready,
  input  logic [ADDR_W-1:0]    i_alu_reg,
  input  logic [DATA_W-1:0]    i_alu_data,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [ADDR_W-1:0]    i_mem_reg,
  input  logic [DATA_W-1:0]    i_mem_data,
  output logic                 o_write_en,
  output logic [ADDR_W-1:0]    o_write_reg,
  output logic [DATA_W-1:0]    o_write_data,
  output logic                 o_grant_src,
  output logic [2**ADDR_W-1:0] o_pending
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(FIFO_DEPTH);

  // Index 0 = ALU source, index 1 = memory-load source.
  logic [ADDR_W-1:0] reg_q  [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [2][FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q [2], wptr_d [2];
  logic [PtrW-1:0]   rptr_q [2], rptr_d [2];
  logic [PtrW:0]     cnt_q  [2], cnt_d  [2];

  logic [ADDR_W-1:0] rin [2];
  logic [DATA_W-1:0] din [2];
  logic [1:0]        vin, rdy, push, pop, nempty;
  logic              grant_mem;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              src_q, src_d;
  logic [PtrW-1:0]   rel;

  always_comb begin
    vin    = {i_mem_valid, i_alu_valid};
    rin[0] = i_alu_reg;
    rin[1] = i_mem_reg;
    din[0] = i_alu_data;
    din[1] = i_mem_data;
    for (int s = 0; s < 2; s++) begin
      nempty[s] = cnt_q[s] != '0;
      rdy[s]    = cnt_q[s] != DepthC;
      // Register 0 completes the handshake but is dropped here.
      push[s]   = vin[s] & rdy[s] & (rin[s] != '0);
    end
  end

  assign o_alu_ready = rdy[0];
  assign o_mem_ready = rdy[1];

`ifdef REGBANK_WB_FIXED_PRIO_EN
  assign grant_mem = nempty[1];
`else
  logic pref_q, pref_d;  // 0 favours ALU, 1 favours MEM

  assign grant_mem = nempty[1] & (~nempty[0] | pref_q);
  assign pref_d    = (|nempty) ? ~grant_mem : pref_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) pref_q <= 1'b0;
    else          pref_q <= pref_d;
  end
`endif

  assign pop = {grant_mem, nempty[0] & ~grant_mem};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = wptr_q[s] + PtrW'(push[s]);
      rptr_d[s] = rptr_q[s] + PtrW'(pop[s]);
      cnt_d[s]  = cnt_q[s] + (PtrW+1)'(push[s]) - (PtrW+1)'(pop[s]);
    end
    we_d    = |nempty;
    src_d   = grant_mem;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_mem) begin
      wreg_d  = reg_q[1][rptr_q[1]];
      wdata_d = data_q[1][rptr_q[1]];
    end else if (nempty[0]) begin
      wreg_d  = reg_q[0][rptr_q[0]];
      wdata_d = data_q[0][rptr_q[0]];
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        reg_q[s][wptr_q[s]]  <= rin[s];
        data_q[s][wptr_q[s]] <= din[s];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
    end
  end

  assign o_write_en   = we_q;
  assign o_write_reg  = wreg_q;
  assign o_write_data = wdata_q;
  assign o_grant_src  = src_q;

  always_comb begin
    o_pending = '0;
    rel       = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rel = PtrW'(i) - rptr_q[s];
        if ({1'b0, rel} < cnt_q[s]) o_pending[reg_q[s][i]] = 1'b1;
      end
    end
    if (we_q) o_pending[wreg_q] = 1'b1;
  end

endmodule
